host_mem_responder: RTL

- Host-side end of the miner's cache-line host interface; serves the requests that the miner's memory controller issues.
- Holds DEPTH 512-bit lines starting at BASE_ADDR and accepts one read or write at a time.
- Returns completions after a fixed LATENCY.
- Used in DMA loopback benches and FPGA self-test builds in place of the real host shim.

---
 rtl/host_mem_if.sv | 29 ++
 rtl/host_mem_responder.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/host_mem_if.sv
// Cache-line host interface between the miner's memory controller (master)
// and the host side that serves its requests (slave).
interface host_mem_if;
  logic         host_re;
  logic         host_rgo;
  logic         host_we;
  logic         host_wgo;
  logic [63:0]  corrected_address;
  logic [511:0] host_data_bus_write_out;
  logic [511:0] host_data_bus_read_in;
  logic         host_rd_ready;
  logic         host_wr_ready;
  logic         busy;
  logic         addr_err;
  logic         protocol_err;
  logic [15:0]  drop_cnt;

  modport master (
    output host_re, host_rgo, host_we, host_wgo, corrected_address, host_data_bus_write_out,
    input  host_data_bus_read_in, host_rd_ready, host_wr_ready, busy, addr_err, protocol_err,
           drop_cnt
  );

  modport slave (
    input  host_re, host_rgo, host_we, host_wgo, corrected_address, host_data_bus_write_out,
    output host_data_bus_read_in, host_rd_ready, host_wr_ready, busy, addr_err, protocol_err,
           drop_cnt
  );
endinterface

// File: rtl/host_mem_responder.sv
// Host-side responder for the miner's cache-line interface: DEPTH 512-bit lines at BASE_ADDR,
// one request at a time, completion pulse a fixed LATENCY clocks after acceptance.
module host_mem_responder #(
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned LATENCY   = 4
) (
  input logic       clk,
  input logic       rst_n,
  host_mem_if.slave bus
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StRdWait = 2'd1;
  localparam logic [1:0] StWrWait = 2'd2;

  localparam logic [7:0] CntLoad = 8'(LATENCY - 1);

  logic [1:0]      state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            in_range_q, in_range_d;
  logic [511:0]    wdata_q, wdata_d;
  logic [511:0]    rdata_q, rdata_d;
  logic            rd_ready_q, rd_ready_d;
  logic            wr_ready_q, wr_ready_d;
  logic            addr_err_q, addr_err_d;
  logic            protocol_err_q, protocol_err_d;
  logic [15:0]     drop_cnt_q, drop_cnt_d;
  logic [DEPTH-1:0] valid_q, valid_d;

  logic [511:0] mem [DEPTH];

  // Address decode; a borrow (addr below BASE_ADDR) wraps off high and is caught by the compare.
  logic [63:0] off;
  logic        addr_in_range;
  logic        unused_off;

  assign off           = bus.corrected_address - BASE_ADDR;
  assign addr_in_range = (bus.corrected_address >= BASE_ADDR) && (off[63:6] < 58'(DEPTH));
  assign unused_off    = ^off[5:0];

  logic idle, accept_rd, accept_wr, proto, drop, wr_commit;

  assign idle      = (state_q == StIdle);
  assign accept_rd = idle & bus.host_rgo & bus.host_re & ~bus.host_wgo;
  assign accept_wr = idle & bus.host_wgo & bus.host_we & ~bus.host_rgo;
  assign proto     = idle & ((bus.host_rgo & bus.host_wgo) |
                             (bus.host_rgo & ~bus.host_re) |
                             (bus.host_wgo & ~bus.host_we));
  assign drop      = ~idle & (bus.host_rgo | bus.host_wgo);
  assign wr_commit = (state_q == StWrWait) && (cnt_q == 8'd0) && in_range_q;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    idx_d          = idx_q;
    in_range_d     = in_range_q;
    wdata_d        = wdata_q;
    rdata_d        = rdata_q;
    valid_d        = valid_q;
    drop_cnt_d     = drop_cnt_q;
    rd_ready_d     = 1'b0;
    wr_ready_d     = 1'b0;
    addr_err_d     = 1'b0;
    protocol_err_d = proto;

    case (state_q)
      StIdle: begin
        if (accept_rd) begin
          state_d    = StRdWait;
          cnt_d      = CntLoad;
          idx_d      = off[6 +: IdxW];
          in_range_d = addr_in_range;
        end else if (accept_wr) begin
          state_d    = StWrWait;
          cnt_d      = CntLoad;
          idx_d      = off[6 +: IdxW];
          in_range_d = addr_in_range;
          wdata_d    = bus.host_data_bus_write_out;
        end
      end
      StRdWait: begin
        if (cnt_q == 8'd0) begin
          state_d    = StIdle;
          rd_ready_d = 1'b1;
          addr_err_d = ~in_range_q;
          if (!in_range_q)          rdata_d = '1;
          else if (valid_q[idx_q])  rdata_d = mem[idx_q];
          else                      rdata_d = '0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StWrWait: begin
        if (cnt_q == 8'd0) begin
          state_d    = StIdle;
          wr_ready_d = 1'b1;
          addr_err_d = ~in_range_q;
          if (in_range_q) valid_d[idx_q] = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      cnt_q          <= 8'd0;
      idx_q          <= '0;
      in_range_q     <= 1'b0;
      wdata_q        <= '0;
      rdata_q        <= '0;
      rd_ready_q     <= 1'b0;
      wr_ready_q     <= 1'b0;
      addr_err_q     <= 1'b0;
      protocol_err_q <= 1'b0;
      drop_cnt_q     <= 16'd0;
      valid_q        <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      in_range_q     <= in_range_d;
      wdata_q        <= wdata_d;
      rdata_q        <= rdata_d;
      rd_ready_q     <= rd_ready_d;
      wr_ready_q     <= wr_ready_d;
      addr_err_q     <= addr_err_d;
      protocol_err_q <= protocol_err_d;
      drop_cnt_q     <= drop_cnt_d;
      valid_q        <= valid_d;
    end
  end

  // Line storage is not reset; the valid bits gate what a read returns.
  always_ff @(posedge clk) begin
    if (wr_commit) mem[idx_q] <= wdata_q;
  end

  assign bus.host_data_bus_read_in = rdata_q;
  assign bus.host_rd_ready         = rd_ready_q;
  assign bus.host_wr_ready         = wr_ready_q;
  assign bus.busy                  = ~idle;
  assign bus.addr_err              = addr_err_q;
  assign bus.protocol_err          = protocol_err_q;
  assign bus.drop_cnt              = drop_cnt_q;

endmodule
